// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder-buffer commit stage.
package rob_pkg;

    localparam int unsigned INDEX_WIDTH = 5;
    localparam int unsigned AREG_WIDTH  = 5;
    localparam int unsigned PREG_WIDTH  = 6;
    localparam int unsigned ROB_DEPTH   = 1 << INDEX_WIDTH;

    typedef struct packed {
        logic valid;
        logic done;
        logic mispredict;
        logic is_branch;
        logic is_store;
    } rob_flags_t;

    typedef struct packed {
        rob_flags_t              flags;
        logic [AREG_WIDTH-1:0]   areg;
        logic [PREG_WIDTH-1:0]   preg;
        logic [PREG_WIDTH-1:0]   old_preg;
    } rob_entry_t;

    // Freshly allocated entry: valid, not yet completed.
    function automatic rob_entry_t new_entry(
        input logic [AREG_WIDTH-1:0] areg,
        input logic [PREG_WIDTH-1:0] preg,
        input logic [PREG_WIDTH-1:0] old_preg,
        input logic                  is_branch,
        input logic                  is_store
    );
        rob_entry_t e;
        e                 = '0;
        e.flags.valid     = 1'b1;
        e.flags.is_branch = is_branch;
        e.flags.is_store  = is_store;
        e.areg            = areg;
        e.preg            = preg;
        e.old_preg        = old_preg;
        return e;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Decides which of the two head slots retire this cycle and how many.
module rob_commit_select
    import rob_pkg::*;
(
    input  rob_flags_t  slot1,
    input  logic        slot2_ready,
    input  logic        slot2_store,
    input  logic        flush_active,
    output logic        commit1_c,
    output logic        commit2_c,
    output logic        mispredict1_c,
    output logic [1:0]  count_c
);

    always_comb begin
        commit1_c     = 1'b0;
        commit2_c     = 1'b0;
        mispredict1_c = 1'b0;
        count_c       = 2'd0;

        commit1_c     = !flush_active && slot1.valid && slot1.done;
        mispredict1_c = commit1_c && slot1.is_branch && slot1.mispredict;
        // Only one store port, and nothing younger than a mispredicted branch retires.
        commit2_c     = commit1_c && slot2_ready && !mispredict1_c
                        && !(slot1.is_store && slot2_store);
        count_c       = 2'(commit1_c) + 2'(commit2_c);
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder-buffer entry store with in-order dual retirement and mispredict flush.
module rob_commit #(
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned AREG_WIDTH  = 5,
    parameter int unsigned PREG_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] head_i,
    input  logic [INDEX_WIDTH-1:0] tail_i,
    input  logic                   ins1_valid_i,
    input  logic [AREG_WIDTH-1:0]  ins1_areg_i,
    input  logic [PREG_WIDTH-1:0]  ins1_preg_i,
    input  logic [PREG_WIDTH-1:0]  ins1_old_preg_i,
    input  logic                   ins1_is_branch_i,
    input  logic                   ins1_is_store_i,
    input  logic                   ins2_valid_i,
    input  logic [AREG_WIDTH-1:0]  ins2_areg_i,
    input  logic [PREG_WIDTH-1:0]  ins2_preg_i,
    input  logic [PREG_WIDTH-1:0]  ins2_old_preg_i,
    input  logic                   ins2_is_branch_i,
    input  logic                   ins2_is_store_i,
    input  logic                   wb1_valid_i,
    input  logic [INDEX_WIDTH-1:0] wb1_index_i,
    input  logic                   wb1_mispredict_i,
    input  logic                   wb2_valid_i,
    input  logic [INDEX_WIDTH-1:0] wb2_index_i,
    input  logic                   wb2_mispredict_i,
    output logic [1:0]             comcnt_o,
    output logic                   cmt1_valid_o,
    output logic [AREG_WIDTH-1:0]  cmt1_areg_o,
    output logic [PREG_WIDTH-1:0]  cmt1_preg_o,
    output logic [PREG_WIDTH-1:0]  cmt1_free_preg_o,
    output logic                   cmt2_valid_o,
    output logic [AREG_WIDTH-1:0]  cmt2_areg_o,
    output logic [PREG_WIDTH-1:0]  cmt2_preg_o,
    output logic [PREG_WIDTH-1:0]  cmt2_free_preg_o,
    output logic                   store_commit_o,
    output logic                   flush_o,
    output logic [INDEX_WIDTH-1:0] flush_tail_o
);
    import rob_pkg::*;

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

    rob_entry_t              entries_q [DEPTH];
    rob_entry_t              entries_d [DEPTH];
    logic                    flush_q;
    logic [INDEX_WIDTH-1:0]  flush_tail_q;

    rob_entry_t              e1;
    logic [INDEX_WIDTH-1:0]  head2;
    logic [INDEX_WIDTH-1:0]  alloc2_idx;
    logic                    commit1;
    logic                    commit2;
    logic                    mispredict1;
    logic [1:0]              count;

    assign head2      = head_i + INDEX_WIDTH'(1);
    assign alloc2_idx = ins1_valid_i ? tail_i + INDEX_WIDTH'(1) : tail_i;
    assign e1         = entries_q[head_i];

    rob_commit_select u_select (
        .slot1         (e1.flags),
        .slot2_ready   (entries_q[head2].flags.valid && entries_q[head2].flags.done),
        .slot2_store   (entries_q[head2].flags.is_store),
        .flush_active  (flush_q),
        .commit1_c     (commit1),
        .commit2_c     (commit2),
        .mispredict1_c (mispredict1),
        .count_c       (count)
    );

    // Next entry state: writeback, then commit clear, then allocation, then flush.
    always_comb begin
        entries_d = entries_q;
        if (!flush_q) begin
            if (wb1_valid_i && entries_q[wb1_index_i].flags.valid) begin
                entries_d[wb1_index_i].flags.done       = 1'b1;
                entries_d[wb1_index_i].flags.mispredict =
                    entries_q[wb1_index_i].flags.mispredict | wb1_mispredict_i;
            end
            if (wb2_valid_i && entries_q[wb2_index_i].flags.valid) begin
                entries_d[wb2_index_i].flags.done       = 1'b1;
                entries_d[wb2_index_i].flags.mispredict =
                    entries_d[wb2_index_i].flags.mispredict | wb2_mispredict_i;
            end
            if (commit1) entries_d[head_i].flags.valid = 1'b0;
            if (commit2) entries_d[head2].flags.valid  = 1'b0;
            if (ins1_valid_i) begin
                entries_d[tail_i] = new_entry(ins1_areg_i, ins1_preg_i, ins1_old_preg_i,
                                              ins1_is_branch_i, ins1_is_store_i);
            end
            if (ins2_valid_i) begin
                entries_d[alloc2_idx] = new_entry(ins2_areg_i, ins2_preg_i, ins2_old_preg_i,
                                                  ins2_is_branch_i, ins2_is_store_i);
            end
            if (mispredict1) begin
                for (int i = 0; i < int'(DEPTH); i++) entries_d[i].flags.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
            flush_q      <= 1'b0;
            flush_tail_q <= '0;
        end else begin
            entries_q <= entries_d;
            flush_q   <= mispredict1;
            if (mispredict1) flush_tail_q <= head2;
        end
    end

    assign comcnt_o         = count;
    assign cmt1_valid_o     = commit1;
    assign cmt1_areg_o      = commit1 ? e1.areg     : '0;
    assign cmt1_preg_o      = commit1 ? e1.preg     : '0;
    assign cmt1_free_preg_o = commit1 ? e1.old_preg : '0;
    assign cmt2_valid_o     = commit2;
    assign cmt2_areg_o      = commit2 ? entries_q[head2].areg     : '0;
    assign cmt2_preg_o      = commit2 ? entries_q[head2].preg     : '0;
    assign cmt2_free_preg_o = commit2 ? entries_q[head2].old_preg : '0;
    assign store_commit_o   = (commit1 && e1.flags.is_store)
                              || (commit2 && entries_q[head2].flags.is_store);
    assign flush_o          = flush_q;
    assign flush_tail_o     = flush_tail_q;

endmodule
